lbp_engine_param: RTL and testbench
===================================

// Module: lbp_engine_param
// PURPOSE
//  Parametrised 3x3 Local Binary Pattern engine for any IMG_W x IMG_H grayscale image of PIX_W-bit pixels.
//  - Fetches pixels from the host gray memory through a req/ready handshake.
//  - Slides a 3x3 window along each row, re-fetching only the new right column.
//  - Writes one LBP code per interior pixel to the lbp memory port; border pixels are never written.
//  - Successor to the fixed 128x128/8-bit LBP block: adds a stall-aware handshake and a row-width-agnostic scan.
// PARAMETERS
//  IMG_W   128  image width in pixels, >= 3
//  IMG_H   128  image height in pixels, >= 3
//  PIX_W   8    gray pixel width in bits
//  ADDR_W  14   address width; must satisfy 2**ADDR_W >= IMG_W*IMG_H
// PORTS
//  clk         in   1       single clock, rising edge
//  reset       in   1       synchronous, active-high
//  gray_addr   out  ADDR_W  pixel read address, row-major (y*IMG_W+x)
//  gray_req    out  1       read request
//  gray_ready  in   1       host accepts the request this cycle
//  gray_data   in   PIX_W   read data, valid the cycle after an accepted request
//  lbp_addr    out  ADDR_W  write address = centre pixel address
//  lbp_valid   out  1       one-cycle write strobe
//  lbp_data    out  8       LBP code
//  finish      out  1       sticky done flag
// BEHAVIOUR
//  Reset: synchronous active-high. Values: gray_addr=0, gray_req=0, lbp_addr=0, lbp_valid=0, lbp_data=0, finish=0.
//   - Reset asserted mid-frame aborts the scan; the window and counters are cleared.
//   - The scan restarts at (1,1) after reset deasserts.
//  FSM: IDLE -> FETCH -> CAPT -> WRITE -> FETCH | DONE.
//   - IDLE lasts 1 cycle after reset.
//   - DONE holds until reset.
//  Handshake:
//   - A request is accepted when gray_req && gray_ready.
//   - On !gray_ready, gray_addr and gray_req hold unchanged (stall).
//   - Exactly one accepted request per pixel needed; gray_data is captured the cycle after acceptance.
//  Fetch order: column-major within the window (top, mid, bottom of the left column, then middle, then right).
//   - First centre of each row (x=1): 9 fetches.
//   - Each later centre: the window shifts left one column; 3 fetches (x+1, rows y-1..y+1).
//  Latency with gray_ready tied high:
//   - First pixel of a row: gray_req high for 9 cycles, 1 CAPT cycle, lbp_valid high in cycle 11.
//   - Later pixels: 3 + 1 + 1 = 5 cycles per pixel.
//   - gray_req is low during CAPT and WRITE.
//  Code: bit_i = (n_i >= centre), unsigned PIX_W-bit compare.
//   - Bit mapping: b0=TL, b1=T, b2=TR, b3=L, b4=R, b5=BL, b6=B, b7=BR.
//   - lbp_data and lbp_addr are stable while lbp_valid=1 and hold afterwards.
//  Scan:
//   - x runs 1..IMG_W-2, y runs 1..IMG_H-2.
//   - Row wrap: after x=IMG_W-2 go to x=1, y+1, and do a full 9-fetch reload.
//   - After writing (IMG_W-2, IMG_H-2), finish rises in the cycle after that lbp_valid and stays high; no further requests.
//   - Total writes: (IMG_W-2)*(IMG_H-2).
//  Widths: all addresses are computed in ADDR_W bits; address arithmetic never wraps for legal parameters.
// CONFIGURATION
//  UNIFORM_MAP_EN:
//   - Defined: the raw 8-bit code goes through a uniform-pattern mapper.
//   - Count circular 0/1 transitions over b0..b7 in ring order b0,b1,b2,b4,b7,b6,b5,b3.
//   - If transitions <= 2, lbp_data = popcount(code), giving 0..8; otherwise lbp_data = 9.
//   - The mapper is combinational in CAPT, so latency is unchanged.
//  Undefined: lbp_data = raw code; mapper logic absent.
// TESTING
//  1. IMG_W=IMG_H=4, all pixels 50, ready=1.
//     -> 4 writes at addrs 5, 6, 9, 10, each lbp_data=8'hFF; finish rises one cycle after the 4th write.
//  2. Same 4x4 image, centre addr 5 = 100, neighbour TR (addr 2) = 200, others 10.
//     -> write at addr 5 carries lbp_data=8'h04.
//  3. Default 128x128 random image vs golden model.
//     -> 15876 writes, last lbp_addr=16254, codes match.
//     -> first write 11 cycles after the first request; later in-row writes every 5 cycles.
//  4. gray_ready low for 3 cycles in the middle of a fetch.
//     -> gray_addr/gray_req frozen; the result is identical to run 1; the write is delayed by exactly 3 cycles.
//  5. reset pulsed for 1 cycle mid-frame (after the 20th write).
//     -> all outputs return to reset values; the rescan starts at addr IMG_W+1; the full write count is restored.
//  6. UNIFORM_MAP_EN, 4x4 constant image -> lbp_data=8; centre with only T and B set (non-uniform) -> lbp_data=9.

Source files
------------

// File: rtl/lbp_engine_param_if.sv
// lbp_engine_param_if: gray-memory read handshake and LBP write port of lbp_engine_param
interface lbp_engine_param_if #(parameter int ADDR_W = 14, parameter int PIX_W = 8);
  logic [ADDR_W-1:0] gray_addr;
  logic gray_req;
  logic gray_ready;
  logic [PIX_W-1:0] gray_data;
  logic [ADDR_W-1:0] lbp_addr;
  logic lbp_valid;
  logic [7:0] lbp_data;
  logic finish;
  modport master (output gray_addr, gray_req, lbp_addr, lbp_valid, lbp_data, finish, input gray_ready, gray_data);
  modport slave (input gray_addr, gray_req, lbp_addr, lbp_valid, lbp_data, finish, output gray_ready, gray_data);
endinterface

// File: rtl/lbp_engine_param.sv
// lbp_engine_param: sliding 3x3 LBP over an IMG_W x IMG_H gray image, one code per interior pixel.
// Define UNIFORM_MAP_EN to emit uniform-pattern classes (0..9) instead of raw codes.
module lbp_engine_param #(
  parameter int IMG_W = 128,
  parameter int IMG_H = 128,
  parameter int PIX_W = 8,
  parameter int ADDR_W = 14
) (
  input logic clk,
  input logic reset,
  lbp_engine_param_if.master bus
);
  typedef enum logic [2:0] {IDLE, FETCH, CAPT, WRITE, DONE} state_t;
  localparam logic [ADDR_W-1:0] W = ADDR_W'(IMG_W);
  localparam logic [ADDR_W-1:0] ONE = ADDR_W'(1);
  state_t state, state_n;
  logic [PIX_W-1:0] win [9];
  logic [ADDR_W-1:0] x, y;
  logic [3:0] k, pidx;
  logic [1:0] col, row;
  logic pend, acc, row_end, last_px;
  logic [7:0] code, mapped;
  assign acc = bus.gray_req && bus.gray_ready;
  assign col = k >= 4'd6 ? 2'd2 : k >= 4'd3 ? 2'd1 : 2'd0;
  assign row = 2'(k - 4'(col) * 4'd3);
  assign row_end = x == ADDR_W'(IMG_W - 2);
  assign last_px = row_end && y == ADDR_W'(IMG_H - 2);
  // window index k is column-major: k = 3*col + row, centre at k=4
  assign bus.gray_addr = (y + ADDR_W'(row) - ONE) * W + x + ADDR_W'(col) - ONE;
  assign bus.gray_req = state == FETCH;
  assign bus.finish = state == DONE;
  // BR arrives on gray_data during CAPT, so it is taken straight from the bus
  assign code = {bus.gray_data >= win[4], win[5] >= win[4], win[2] >= win[4], win[7] >= win[4],
                 win[1] >= win[4], win[6] >= win[4], win[3] >= win[4], win[0] >= win[4]};
`ifdef UNIFORM_MAP_EN
  logic [7:0] ring;
  logic [3:0] trans, ones;
  assign ring = {code[3], code[5], code[6], code[7], code[4], code[2], code[1], code[0]};
  always_comb begin
    trans = '0;
    ones = '0;
    for (int i = 0; i < 8; i++) begin
      trans = trans + 4'(ring[i] ^ ring[(i + 1) % 8]);
      ones = ones + 4'(code[i]);
    end
  end
  assign mapped = trans <= 4'd2 ? {4'd0, ones} : 8'd9;
`else
  assign mapped = code;
`endif
  always_comb begin
    state_n = state;
    state_n = state == IDLE ? FETCH :
              state == FETCH ? (acc && k == 4'd8 ? CAPT : FETCH) :
              state == CAPT ? WRITE :
              state == WRITE ? (last_px ? DONE : FETCH) : DONE;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      x <= ONE;
      y <= ONE;
      k <= '0;
      pidx <= '0;
      pend <= 1'b0;
      for (int i = 0; i < 9; i++) win[i] <= '0;
      bus.lbp_addr <= '0;
      bus.lbp_valid <= 1'b0;
      bus.lbp_data <= '0;
    end else begin
      state <= state_n;
      pend <= acc;
      pidx <= k;
      bus.lbp_valid <= state == CAPT;
      if (pend) win[pidx] <= bus.gray_data;
      if (acc && k != 4'd8) k <= k + 4'd1;
      if (state == CAPT) begin
        bus.lbp_data <= mapped;
        bus.lbp_addr <= y * W + x;
      end
      if (state == WRITE) begin
        x <= row_end ? ONE : x + ONE;
        y <= row_end ? y + ONE : y;
        k <= row_end ? 4'd0 : 4'd6;
        if (!row_end) for (int i = 0; i < 6; i++) win[i] <= win[i + 3];
      end
    end
  end
endmodule

// File: tb/tb_lbp_engine_param.sv
// tb_lbp_engine_param: directed + random frames on a 7x5 image, scoreboard of expected LBP writes.
module tb_lbp_engine_param;
  localparam int W = 7, H = 5, PW = 8, AW = 6, NW = (W - 2) * (H - 2);
  localparam int DX [8] = '{-1, 0, 1, -1, 1, -1, 0, 1};
  localparam int DY [8] = '{-1, -1, -1, 0, 0, 1, 1, 1};
  localparam int RG [8] = '{0, 1, 2, 4, 7, 6, 5, 3};
  typedef struct packed {logic [AW-1:0] addr; logic [7:0] data;} wr_t;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [PW-1:0] mem [W*H];
  wr_t sbq [$];
  int compared = 0, mismatched = 0;
  logic [7:0] first_data;
  logic [AW-1:0] first_addr;
  always #5 clk = ~clk;
  lbp_engine_param_if #(.ADDR_W(AW), .PIX_W(PW)) bus ();
  lbp_engine_param #(.IMG_W(W), .IMG_H(H), .PIX_W(PW), .ADDR_W(AW)) dut (.clk(clk), .reset(reset), .bus(bus));
  always @(posedge clk) if (bus.gray_req && bus.gray_ready) bus.gray_data <= mem[bus.gray_addr];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] model(int cx, int cy);
    logic [7:0] c;
    int t, p;
    for (int i = 0; i < 8; i++) c[i] = mem[(cy + DY[i]) * W + cx + DX[i]] >= mem[cy * W + cx];
`ifdef UNIFORM_MAP_EN
    t = 0;
    p = 0;
    for (int i = 0; i < 8; i++) begin
      t += (c[RG[i]] != c[RG[(i + 1) % 8]]) ? 1 : 0;
      p += c[i] ? 1 : 0;
    end
    c = t <= 2 ? 8'(p) : 8'd9;
`endif
    return c;
  endfunction

  task automatic build_expected();
    sbq.delete();
    for (int yy = 1; yy <= H - 2; yy++)
      for (int xx = 1; xx <= W - 2; xx++) sbq.push_back({AW'(yy * W + xx), model(xx, yy)});
  endtask

  task automatic check_reset();
    chk("rst_gray_addr", bus.gray_addr, 0);
    chk("rst_gray_req", bus.gray_req, 0);
    chk("rst_lbp_addr", bus.lbp_addr, 0);
    chk("rst_lbp_valid", bus.lbp_valid, 0);
    chk("rst_lbp_data", bus.lbp_data, 0);
    chk("rst_finish", bus.finish, 0);
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    @(negedge clk);
    check_reset();
    reset = 1'b0;
  endtask

  task automatic run_frame(input int stall, input int abort_after);
    int n = 0, first_req = -1, last_wr = -1, writes = 0, lim;
    logic [AW-1:0] held;
    wr_t e;
    lim = abort_after > 0 ? abort_after : NW;
    while (writes < lim && n < 2000) begin
      @(negedge clk);
      n++;
      if (first_req < 0 && bus.gray_req) first_req = n;
      if (stall > 0 && first_req > 0 && n == first_req + 3) begin
        held = bus.gray_addr;
        bus.gray_ready = 1'b0;
        repeat (stall) begin
          @(negedge clk);
          n++;
          chk("stall_addr", bus.gray_addr, held);
          chk("stall_req", bus.gray_req, 1);
          chk("stall_valid", bus.lbp_valid, 0);
        end
        bus.gray_ready = 1'b1;
      end
      if (bus.lbp_valid) begin
        writes++;
        chk("sb_available", sbq.size() > 0, 1);
        e = sbq.size() > 0 ? sbq.pop_front() : '0;
        chk("lbp_addr", bus.lbp_addr, e.addr);
        chk("lbp_data", bus.lbp_data, e.data);
        chk("finish_early", bus.finish, 0);
        if (writes == 1) begin
          first_data = bus.lbp_data;
          first_addr = bus.lbp_addr;
          chk("first_latency", n - first_req, 10 + stall);
        end else chk("write_pitch", n - last_wr, (int'(e.addr) % W == 1) ? 11 : 5);
        last_wr = n;
      end
    end
    chk("writes_seen", writes, lim);
  endtask

  task automatic check_done();
    @(negedge clk);
    chk("finish_rise", bus.finish, 1);
    chk("done_req", bus.gray_req, 0);
    chk("done_valid", bus.lbp_valid, 0);
    repeat (4) @(negedge clk);
    chk("finish_sticky", bus.finish, 1);
    chk("done_req_hold", bus.gray_req, 0);
    chk("data_hold", bus.lbp_data, sbq.size() == 0 ? model(W - 2, H - 2) : 8'hxx);
  endtask

  initial begin
    bus.gray_ready = 1'b1;
    foreach (mem[i]) mem[i] = 8'd50;
    repeat (2) @(negedge clk);
    check_reset();
    build_expected();
    reset = 1'b0;
    run_frame(0, 0);
`ifdef UNIFORM_MAP_EN
    chk("const_code", first_data, 8'd8);
`else
    chk("const_code", first_data, 8'hFF);
`endif
    check_done();

    foreach (mem[i]) mem[i] = 8'd10;
    mem[W + 1] = 8'd100;
    mem[2] = 8'd200;
    build_expected();
    pulse_reset();
    run_frame(0, 0);
`ifdef UNIFORM_MAP_EN
    chk("tr_code", first_data, 8'd1);
`else
    chk("tr_code", first_data, 8'h04);
`endif
    check_done();

    foreach (mem[i]) mem[i] = 8'd10;
    mem[W + 1] = 8'd100;
    mem[1] = 8'd200;
    mem[2 * W + 1] = 8'd200;
    build_expected();
    pulse_reset();
    run_frame(0, 0);
`ifdef UNIFORM_MAP_EN
    chk("tb_code", first_data, 8'd9);
`else
    chk("tb_code", first_data, 8'h42);
`endif
    check_done();

    foreach (mem[i]) mem[i] = PW'($urandom_range(0, 3));
    build_expected();
    pulse_reset();
    run_frame(3, 0);
    check_done();

    foreach (mem[i]) mem[i] = PW'($urandom_range(0, 255));
    mem[0] = 8'd0;
    mem[W * H - 1] = 8'd255;
    build_expected();
    pulse_reset();
    run_frame(0, 8);
    pulse_reset();
    build_expected();
    run_frame(0, 0);
    chk("rescan_first_addr", first_addr, W + 1);
    check_done();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
